// File: rtl/knn_pkg.sv
// knn_pkg: shared types for the BDU datapath and its feeder.
package knn_pkg;

    localparam int B_DEFAULT = 32;

    typedef enum logic [1:0] {
        CODE_NONE = 2'b00,
        CODE_X    = 2'b01,
        CODE_Y    = 2'b10,
        CODE_Z    = 2'b11
    } coord_code_e;

    typedef struct packed {
        logic [B_DEFAULT-1:0] x;
        logic [B_DEFAULT-1:0] y;
        logic [B_DEFAULT-1:0] z;
    } point_t;

endpackage

// File: rtl/bdu_feeder_if.sv
// bdu_feeder_if: reference handshake, BDU bit stream and retire report.
interface bdu_feeder_if
    import knn_pkg::*;
#(
    parameter int B     = B_DEFAULT,
    parameter int IDX_W = 16
);
    localparam int BW = $clog2(B + 1);

    logic              q_load;
    logic [B-1:0]      q_x, q_y, q_z;
    logic              ref_valid;
    logic              ref_ready;
    logic [B-1:0]      ref_x, ref_y, ref_z;
    logic              bdu_clear;
    logic              valid;
    logic              q_bit, r_bit;
    coord_code_e       code;
    logic [BW-1:0]     b;
    logic              terminate;
    logic              done;
    logic              pt_done;
    logic              pt_term;
    logic [IDX_W-1:0]  pt_idx;

    modport master (
        input  q_load, q_x, q_y, q_z,
        input  ref_valid, ref_x, ref_y, ref_z,
        input  terminate, done,
        output ref_ready, bdu_clear, valid,
        output q_bit, r_bit, code, b,
        output pt_done, pt_term, pt_idx
    );

    modport slave (
        output q_load, q_x, q_y, q_z,
        output ref_valid, ref_x, ref_y, ref_z,
        output terminate, done,
        input  ref_ready, bdu_clear, valid,
        input  q_bit, r_bit, code, b,
        input  pt_done, pt_term, pt_idx
    );

endinterface

// File: rtl/bit_step_counter.sv
// bit_step_counter: x/y/z lane rotation plus bit position 1..B.
module bit_step_counter
    import knn_pkg::*;
#(
    parameter int B  = B_DEFAULT,
    parameter int BW = $clog2(B + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step,
    input  logic          stop,
    output coord_code_e   code,
    output coord_code_e   code_n,
    output logic [BW-1:0] b,
    output logic [BW-1:0] b_n,
    output logic          last
);

    always_comb begin
        code_n = code;
        b_n    = b;
        unique case (1'b1)
            stop: begin
                code_n = CODE_NONE;
                b_n    = '0;
            end
            start: begin
                code_n = CODE_X;
                b_n    = BW'(1);
            end
            step: begin
                unique case (code)
                    CODE_X: code_n = CODE_Y;
                    CODE_Y: code_n = CODE_Z;
                    CODE_Z: begin
                        code_n = CODE_X;
                        b_n    = b + BW'(1);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign last = (code == CODE_Z) && (b == BW'(B));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code <= CODE_NONE;
            b    <= '0;
        end else begin
            code <= code_n;
            b    <= b_n;
        end
    end

endmodule

// File: rtl/bdu_feeder.sv
// bdu_feeder: holds a query point and streams query/reference pairs
// MSB-first, x/y/z interleaved, into the BDU; retires on done/terminate.
module bdu_feeder
    import knn_pkg::*;
#(
    parameter int B     = B_DEFAULT,
    parameter int IDX_W = 16
) (
    input logic          clk,
    input logic          rst,
    bdu_feeder_if.master bus
);
    localparam int BW = $clog2(B + 1);
    localparam int IW = $clog2(B);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_STREAM, S_WAIT, S_RETIRE
    } state_e;

    state_e           state, state_n;
    logic             q_loaded, q_loaded_n;
    logic [B-1:0]     qry [3];
    logic [B-1:0]     rpt [3];
    logic             ld_q, ld_r;
    logic             ref_ready_n, bdu_clear_n, valid_n;
    logic             pt_done_n, pt_term_n;
    logic             q_bit_n, r_bit_n;
    logic [IDX_W-1:0] pt_idx_n;
    logic             cnt_start, cnt_step, cnt_stop, last;
    coord_code_e      code, code_n;
    logic [BW-1:0]    bpos, bpos_n;
    logic [IW-1:0]    sel;

    bit_step_counter #(.B(B), .BW(BW)) u_step (
        .clk    (clk),
        .rst    (rst),
        .start  (cnt_start),
        .step   (cnt_step),
        .stop   (cnt_stop),
        .code   (code),
        .code_n (code_n),
        .b      (bpos),
        .b_n    (bpos_n),
        .last   (last)
    );

    assign bus.code = code;
    assign bus.b    = bpos;

    always_comb begin
        state_n     = state;
        q_loaded_n  = q_loaded;
        ld_q        = 1'b0;
        ld_r        = 1'b0;
        ref_ready_n = 1'b0;
        bdu_clear_n = 1'b0;
        valid_n     = 1'b0;
        pt_done_n   = 1'b0;
        pt_term_n   = 1'b0;
        pt_idx_n    = bus.pt_idx;
        cnt_start   = 1'b0;
        cnt_step    = 1'b0;
        cnt_stop    = 1'b0;
        unique case (state)
            S_IDLE: begin
                // a query load shadows any reference offered the same cycle
                if (bus.q_load) begin
                    ld_q        = 1'b1;
                    q_loaded_n  = 1'b1;
                    ref_ready_n = 1'b1;
                end else if (bus.ref_valid && bus.ref_ready) begin
                    ld_r        = 1'b1;
                    bdu_clear_n = 1'b1;
                    state_n     = S_CLEAR;
                end else begin
                    ref_ready_n = q_loaded;
                end
            end
            S_CLEAR: begin
                cnt_start = 1'b1;
                valid_n   = 1'b1;
                state_n   = S_STREAM;
            end
            S_STREAM: begin
                if (bus.terminate || (last && bus.done)) begin
                    cnt_stop  = 1'b1;
                    pt_done_n = 1'b1;
                    pt_term_n = bus.terminate;
                    state_n   = S_RETIRE;
                end else if (last) begin
                    cnt_stop = 1'b1;
                    state_n  = S_WAIT;
                end else begin
                    cnt_step = 1'b1;
                    valid_n  = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.terminate || bus.done) begin
                    pt_done_n = 1'b1;
                    pt_term_n = bus.terminate;
                    state_n   = S_RETIRE;
                end
            end
            S_RETIRE: begin
                pt_idx_n    = bus.pt_idx + IDX_W'(1);
                ref_ready_n = q_loaded;
                state_n     = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // bits are looked up for the step the counter moves to next
    always_comb begin
        q_bit_n = 1'b0;
        r_bit_n = 1'b0;
        sel     = IW'(BW'(B) - bpos_n);
        unique case (code_n)
            CODE_X: begin
                q_bit_n = qry[0][sel];
                r_bit_n = rpt[0][sel];
            end
            CODE_Y: begin
                q_bit_n = qry[1][sel];
                r_bit_n = rpt[1][sel];
            end
            CODE_Z: begin
                q_bit_n = qry[2][sel];
                r_bit_n = rpt[2][sel];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            q_loaded      <= 1'b0;
            qry           <= '{default: '0};
            rpt           <= '{default: '0};
            bus.ref_ready <= 1'b0;
            bus.bdu_clear <= 1'b0;
            bus.valid     <= 1'b0;
            bus.q_bit     <= 1'b0;
            bus.r_bit     <= 1'b0;
            bus.pt_done   <= 1'b0;
            bus.pt_term   <= 1'b0;
            bus.pt_idx    <= '0;
        end else begin
            state         <= state_n;
            q_loaded      <= q_loaded_n;
            bus.ref_ready <= ref_ready_n;
            bus.bdu_clear <= bdu_clear_n;
            bus.valid     <= valid_n;
            bus.q_bit     <= q_bit_n;
            bus.r_bit     <= r_bit_n;
            bus.pt_done   <= pt_done_n;
            bus.pt_term   <= pt_term_n;
            bus.pt_idx    <= pt_idx_n;
            if (ld_q) begin
                qry[0] <= bus.q_x;
                qry[1] <= bus.q_y;
                qry[2] <= bus.q_z;
            end
            if (ld_r) begin
                rpt[0] <= bus.ref_x;
                rpt[1] <= bus.ref_y;
                rpt[2] <= bus.ref_z;
            end
        end
    end

endmodule

// File: tb/tb_bdu_feeder.sv
// tb_bdu_feeder: random and directed points against a bit-level model,
// with a small BDU responder that raises terminate/done on demand.
module tb_bdu_feeder;
    import knn_pkg::*;

    localparam int B     = B_DEFAULT;
    localparam int IDX_W = 16;
    localparam int NB    = 3 * B;

    typedef struct {
        point_t q;
        point_t r;
        int     idx;
        bit     term;
        int     nbits;
    } pend_t;

    typedef struct {
        int term_at;
        int done_lat;
        bit both;
    } cfg_t;

    typedef struct {
        coord_code_e code;
        int          b;
        bit          qb;
        bit          rb;
    } bit_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bdu_feeder_if #(.B(B), .IDX_W(IDX_W)) bus ();

    bdu_feeder #(.B(B), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int     checks    = 0;
    int     errors    = 0;
    int     clear_cnt = 0;
    int     sent_cnt  = 0;
    int     next_idx  = 0;
    pend_t  pend_q[$];
    cfg_t   cfg_q[$];
    bit_t   cur_bits[$];
    pend_t  cur;
    bit     cur_open  = 1'b0;
    point_t mq;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic cfg_t mk_cfg(input int t, input int d, input bit bo);
        cfg_t c;
        c.term_at  = t;
        c.done_lat = d;
        c.both     = bo;
        return c;
    endfunction

    function automatic point_t rand_pt();
        point_t p;
        p.x = $urandom;
        p.y = $urandom;
        p.z = $urandom;
        return p;
    endfunction

    function automatic point_t same_pt(input logic [B-1:0] v);
        point_t p;
        p.x = v;
        p.y = v;
        p.z = v;
        return p;
    endfunction

    // step i: axis i%3, coordinate bit B-1-i/3, reported position i/3+1
    function automatic bit_t ref_bit(input point_t q, input point_t r,
                                     input int i);
        bit_t         e;
        int           ax;
        int           pos;
        logic [B-1:0] qc, rc;
        ax  = i % 3;
        pos = B - 1 - i / 3;
        qc  = (ax == 0) ? q.x : (ax == 1) ? q.y : q.z;
        rc  = (ax == 0) ? r.x : (ax == 1) ? r.y : r.z;
        e.code = coord_code_e'(ax + 1);
        e.b    = i / 3 + 1;
        e.qb   = qc[pos];
        e.rb   = rc[pos];
        return e;
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        bit_t e;
        if (!rst) begin
            cur_bits.delete();
            cur_open = 1'b0;
        end else begin
            if (bus.bdu_clear) begin
                clear_cnt++;
                chk("clear_expected", (pend_q.size() > 0) && !cur_open, 1);
                if (pend_q.size() > 0) begin
                    cur      = pend_q.pop_front();
                    cur_open = 1'b1;
                    cur_bits.delete();
                    for (int i = 0; i < cur.nbits; i++)
                        cur_bits.push_back(ref_bit(cur.q, cur.r, i));
                end
            end
            if (bus.valid) begin
                chk("ready_in_stream", bus.ref_ready, 0);
                chk("bit_expected", cur_bits.size() != 0, 1);
                if (cur_bits.size() != 0) begin
                    e = cur_bits.pop_front();
                    chk("code", bus.code, e.code);
                    chk("b", bus.b, e.b);
                    chk("q_bit", bus.q_bit, e.qb);
                    chk("r_bit", bus.r_bit, e.rb);
                end
            end else begin
                chk("code_idle", bus.code, CODE_NONE);
            end
            if (bus.pt_done) begin
                chk("pt_done_open", cur_open, 1);
                chk("bits_left", cur_bits.size(), 0);
                chk("pt_idx", bus.pt_idx, cur.idx);
                chk("pt_term", bus.pt_term, cur.term);
                cur_open = 1'b0;
            end
        end
    end

    // BDU responder
    cfg_t bc;
    bit   bact;
    int   vcnt, wcnt;

    always @(negedge clk) begin
        if (!rst || bus.pt_done) begin
            bus.terminate = 1'b0;
            bus.done      = 1'b0;
            bact          = 1'b0;
        end else if (bus.bdu_clear) begin
            bact = (cfg_q.size() != 0);
            if (bact) bc = cfg_q.pop_front();
            vcnt = 0;
            wcnt = 0;
        end else if (bact) begin
            if (bus.valid) begin
                if (vcnt == bc.term_at) bus.terminate = 1'b1;
                if (vcnt == NB - 1 && bc.done_lat == 0) begin
                    bus.done = 1'b1;
                    if (bc.both) bus.terminate = 1'b1;
                end
                vcnt++;
            end else begin
                wcnt++;
                if (wcnt == bc.done_lat) begin
                    bus.done = 1'b1;
                    if (bc.both) bus.terminate = 1'b1;
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_ref_ready"}, bus.ref_ready, 0);
        chk({tag, "_bdu_clear"}, bus.bdu_clear, 0);
        chk({tag, "_valid"}, bus.valid, 0);
        chk({tag, "_q_bit"}, bus.q_bit, 0);
        chk({tag, "_r_bit"}, bus.r_bit, 0);
        chk({tag, "_pt_done"}, bus.pt_done, 0);
        chk({tag, "_pt_term"}, bus.pt_term, 0);
        chk({tag, "_code"}, bus.code, 0);
        chk({tag, "_b"}, bus.b, 0);
        chk({tag, "_pt_idx"}, bus.pt_idx, 0);
    endtask

    task automatic load_q(input point_t p);
        @(negedge clk);
        bus.q_load = 1'b1;
        bus.q_x    = p.x;
        bus.q_y    = p.y;
        bus.q_z    = p.z;
        @(posedge clk);
        #1 bus.q_load = 1'b0;
        mq = p;
    endtask

    task automatic push_point(input point_t q, input point_t r,
                              input cfg_t c);
        pend_t p;
        p.q     = q;
        p.r     = r;
        p.idx   = next_idx;
        p.term  = (c.term_at >= 0) || c.both;
        p.nbits = (c.term_at >= 0) ? c.term_at + 1 : NB;
        pend_q.push_back(p);
        cfg_q.push_back(c);
        next_idx = (next_idx + 1) % (1 << IDX_W);
    endtask

    task automatic send_ref(input point_t r, input cfg_t c, input bit hold);
        int n;
        n = 0;
        push_point(mq, r, c);
        @(negedge clk);
        bus.ref_valid = 1'b1;
        bus.ref_x     = r.x;
        bus.ref_y     = r.y;
        bus.ref_z     = r.z;
        while (!bus.ref_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ref_accept", bus.ref_ready, 1);
        @(posedge clk);
        #1;
        sent_cnt++;
        if (!hold) bus.ref_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((cur_open || pend_q.size() != 0 || !bus.ref_ready)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", n < 3000, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        point_t r, nq;
        int     c0;
        cfg_t   c;

        bus.q_load    = 1'b0;
        bus.q_x       = '0;
        bus.q_y       = '0;
        bus.q_z       = '0;
        bus.ref_valid = 1'b0;
        bus.ref_x     = '0;
        bus.ref_y     = '0;
        bus.ref_z     = '0;

        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // no query loaded yet: offers must be refused
        bus.ref_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("noq_ready", bus.ref_ready, 0);
            chk("noq_clear", bus.bdu_clear, 0);
        end
        bus.ref_valid = 1'b0;

        // single full point; a mid-stream q_load must be ignored
        load_q(same_pt(32'h0000_FFFD));
        send_ref(same_pt(32'h0000_FFFF), mk_cfg(-1, 2, 1'b0), 1'b0);
        repeat (10) @(negedge clk);
        bus.q_load = 1'b1;
        bus.q_x    = $urandom;
        bus.q_y    = $urandom;
        bus.q_z    = $urandom;
        @(negedge clk);
        bus.q_load = 1'b0;
        wait_idle();

        // early terminate on stream cycle 20
        send_ref(rand_pt(), mk_cfg(20, 0, 1'b0), 1'b0);
        wait_idle();

        // back-to-back with ref_valid held high
        c0 = clear_cnt;
        send_ref(rand_pt(), mk_cfg(-1, 1, 1'b0), 1'b1);
        send_ref(rand_pt(), mk_cfg(-1, 1, 1'b0), 1'b1);
        send_ref(rand_pt(), mk_cfg(-1, 1, 1'b0), 1'b0);
        wait_idle();
        chk("b2b_clears", clear_cnt - c0, 3);

        // q_load collides with ref_valid in IDLE
        nq = rand_pt();
        r  = rand_pt();
        push_point(nq, r, mk_cfg(-1, 1, 1'b0));
        @(negedge clk);
        bus.q_load    = 1'b1;
        bus.q_x       = nq.x;
        bus.q_y       = nq.y;
        bus.q_z       = nq.z;
        bus.ref_valid = 1'b1;
        bus.ref_x     = r.x;
        bus.ref_y     = r.y;
        bus.ref_z     = r.z;
        @(posedge clk);
        #1 bus.q_load = 1'b0;
        @(negedge clk);
        chk("collide_no_clear", bus.bdu_clear, 0);
        chk("collide_ready", bus.ref_ready, 1);
        @(posedge clk);
        #1 bus.ref_valid = 1'b0;
        sent_cnt++;
        mq = nq;
        wait_idle();

        // terminate with done, in WAIT and on the final stream cycle
        send_ref(rand_pt(), mk_cfg(-1, 2, 1'b1), 1'b0);
        wait_idle();
        send_ref(rand_pt(), mk_cfg(-1, 0, 1'b1), 1'b0);
        wait_idle();
        send_ref(rand_pt(), mk_cfg(-1, 0, 1'b0), 1'b0);
        wait_idle();

        // reset on stream cycle 40 discards the point
        send_ref(rand_pt(), mk_cfg(-1, 3, 1'b0), 1'b0);
        repeat (41) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_zero("midrst");
        pend_q.delete();
        cfg_q.delete();
        next_idx = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_ready", bus.ref_ready, 0);
        load_q(rand_pt());
        send_ref(rand_pt(), mk_cfg(-1, 1, 1'b0), 1'b0);
        wait_idle();

        // random traffic
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                wait_idle();
                load_q(rand_pt());
            end
            c.term_at  = ($urandom_range(0, 9) < 4) ? -1
                       : int'($urandom_range(0, NB - 1));
            c.done_lat = int'($urandom_range(0, 4));
            c.both     = ($urandom_range(0, 4) == 0);
            send_ref(rand_pt(), c, 1'b0);
        end
        wait_idle();

        chk("clear_count", clear_cnt, sent_cnt);
        chk("pending_empty", pend_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
